muldiv_seq: RTL and testbench

Multi-cycle sequencer for the multiply and divide operations of the datapath ALU. It accepts a start pulse with two 32-bit signed operands and runs a radix-2 Booth multiply or a signed restoring divide over 32 iteration cycles. It then returns a 64-bit result formatted for the HI/LO register pair. It frees the single-cycle ALU path from the long mul/div combinational chain, and the control unit stalls on `busy`.

---
 rtl/muldiv_seq.sv | 132 +++++++++++++
 tb/tb_muldiv_seq.sv | 127 ++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring on magnitudes) for the HI/LO pair.
// 33-cycle latency from start to done (1 cycle for divide by zero); start is ignored while busy.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] C,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_nxt;
  logic             fin;
  logic             opr, sa, sb, q1, zdiv;
  logic [WIDTH:0]   p, m;
  logic [WIDTH-1:0] q, n, d, r, a_lat;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   p_sum, r_sh, t;
  logic [WIDTH-1:0] a_mag, b_mag, quo, rem;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (op && B == '0) ? FIN : RUN;
      RUN:     if (cnt == '0) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    fin  = (state == FIN);
  end

  always_comb begin
    p_sum = p;
    case ({q[0], q1})
      2'b01:   p_sum = p + m;
      2'b10:   p_sum = p - m;
      default: p_sum = p;
    endcase
    // Remainder is always below the divisor, so WIDTH bits hold it; the shift is evaluated at WIDTH+1.
    r_sh  = {r, n[WIDTH-1]};
    t     = r_sh - {1'b0, d};
    a_mag = A[WIDTH-1] ? -A : A;
    b_mag = B[WIDTH-1] ? -B : B;
    quo   = (sa ^ sb) ? -n : n;
    rem   = sa ? -r : r;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      opr   <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      q1    <= 1'b0;
      zdiv  <= 1'b0;
      p     <= '0;
      m     <= '0;
      q     <= '0;
      n     <= '0;
      d     <= '0;
      r     <= '0;
      a_lat <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          opr   <= op;
          a_lat <= A;
          zdiv  <= op && (B == '0);
          cnt   <= CW'(WIDTH - 1);
          p     <= '0;
          q     <= A;
          q1    <= 1'b0;
          m     <= {B[WIDTH-1], B};
          r     <= '0;
          n     <= a_mag;
          d     <= b_mag;
          sa    <= A[WIDTH-1];
          sb    <= B[WIDTH-1];
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (opr) begin
            r <= t[WIDTH] ? r_sh[WIDTH-1:0] : t[WIDTH-1:0];
            n <= {n[WIDTH-2:0], ~t[WIDTH]};
          end else begin
            p  <= {p_sum[WIDTH], p_sum[WIDTH:1]};
            q  <= {p_sum[0], q[WIDTH-1:1]};
            q1 <= q[0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      done        <= 1'b0;
      C           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= fin;
      if (fin) begin
        div_by_zero <= opr && zdiv;
        if (!opr)      C <= {p[WIDTH-1:0], q};
        else if (zdiv) C <= {a_lat, {WIDTH{1'b1}}};
        else           C <= {rem, quo};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: signed mul/div results, latency, busy width, hold, ignore and clear behaviour.
module tb_muldiv_seq;

  logic        clock = 1'b0;
  logic        clear, start, op;
  logic [31:0] A, B;
  logic        busy, done, div_by_zero;
  logic [63:0] C;
  logic [63:0] last_c;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clock = ~clock;

  muldiv_seq #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .C           (C),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clock); @(negedge clock);
    start = 1'b0; op = ~o; A = $urandom; B = $urandom;
  endtask

  task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_c, input logic exp_dbz, input int exp_lat, input int inject);
    int cnt  = 0;
    int bcnt = 0;
    issue(o, a, b);
    while (!done && cnt < 100) begin
      if (busy) bcnt++;
      if (cnt == 5) chk({tag, ".hold"}, C, last_c);
      if (cnt == inject) begin
        start = 1'b1; op = 1'b1; A = 32'd3; B = 32'd3;
      end
      @(posedge clock); @(negedge clock);
      start = 1'b0;
      cnt++;
    end
    chk({tag, ".lat"},  64'(cnt),  64'(exp_lat));
    chk({tag, ".busy"}, 64'(bcnt), 64'(exp_lat));
    chk({tag, ".bsy0"}, 64'(busy), 64'd0);
    chk({tag, ".C"},    C, exp_c);
    chk({tag, ".dbz"},  64'(div_by_zero), 64'(exp_dbz));
    last_c = exp_c;
  endtask

  task automatic drop(input string tag);
    @(posedge clock); @(negedge clock);
    chk({tag, ".done1"}, 64'(done), 64'd0);
    chk({tag, ".held"},  C, last_c);
  endtask

  initial begin
    int seen;
    clear = 1'b1; start = 1'b0; op = 1'b0; A = '0; B = '0;
    last_c = '0;
    #12;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.C",    C, 64'd0);
    chk("rst.dbz",  64'(div_by_zero), 64'd0);
    @(negedge clock); clear = 1'b0;
    @(negedge clock);

    run_op("mul7", 1'b0, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 33, -1);
    drop("mul7");
    run_op("mulmin", 1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 33, -1);
    run_op("mulmaxmin", 1'b0, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, 1'b0, 33, -1);
    run_op("divm7", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 33, -1);
    run_op("div100", 1'b1, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 33, -1);
    run_op("divovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 1'b0, 33, -1);
    run_op("div7m3", 1'b1, 32'd7, 32'hFFFFFFFD, {32'd1, 32'hFFFFFFFE}, 1'b0, 33, -1);
    drop("div7m3");
    run_op("div0", 1'b1, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 1'b1, 1, -1);
    drop("div0");
    chk("div0.dbzheld", 64'(div_by_zero), 64'd1);
    run_op("mulclr", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1, 1'b0, 33, -1);
    drop("mulclr");
    run_op("mulign", 1'b0, 32'd12345, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFF9F8E, 1'b0, 33, 10);
    drop("mulign");

    // Second operation starts in the done cycle of the first.
    run_op("b2b1", 1'b0, 32'd100000, 32'd100000, 64'h00000002_540BE400, 1'b0, 33, -1);
    run_op("b2b2", 1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 1'b0, 33, -1);
    drop("b2b2");

    issue(1'b1, 32'd1000, 32'd3);
    repeat (15) @(negedge clock);
    clear = 1'b1;
    #1;
    chk("clr.busy", 64'(busy), 64'd0);
    chk("clr.done", 64'(done), 64'd0);
    chk("clr.C",    C, 64'd0);
    chk("clr.dbz",  64'(div_by_zero), 64'd0);
    @(negedge clock); clear = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done || busy) seen = 1;
    end
    chk("clr.idle", 64'(seen), 64'd0);
    last_c = '0;
    run_op("mulpost", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1, 1'b0, 33, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
